// File: rtl/vga_timing_pkg.sv
// Shared timing constants, derived totals and controller state type for the
// 640x480@60 Hz VGA raster. Optional build macro: VGA_PIXEL_PREFETCH_EN.
package vga_timing_pkg;

   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FP     = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BP     = 48;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FP     = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BP     = 33;

   localparam int DEF_H_TOTAL      = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
   localparam int DEF_V_TOTAL      = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
   localparam int DEF_H_SYNC_START = DEF_H_ACTIVE + DEF_H_FP;
   localparam int DEF_H_SYNC_END   = DEF_H_SYNC_START + DEF_H_SYNC - 1;
   localparam int DEF_V_SYNC_START = DEF_V_ACTIVE + DEF_V_FP;
   localparam int DEF_V_SYNC_END   = DEF_V_SYNC_START + DEF_V_SYNC - 1;

   localparam int H_COUNT_W = 10;
   localparam int V_COUNT_W = 16;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACQUIRE = 2'd1,
      RUN     = 2'd2,
      DRAIN   = 2'd3
   } state_t;

   // Inclusive range test used by the sync decoders.
   function automatic logic in_range16(input logic [15:0] value,
                                       input logic [15:0] lo,
                                       input logic [15:0] hi);
      return (value >= lo) && (value <= hi);
   endfunction

endpackage

// File: rtl/vga_timing_controller_if.sv
// Bundle between the timing controller, the external vertical counter and
// the pixel generator. The master side is the timing controller.
interface vga_timing_controller_if;

   logic        display_en;
   logic [15:0] v_count_value;
   logic        enable_v_counter;
   logic [9:0]  h_count;
   logic        hsync;
   logic        vsync;
   logic        video_on;
   logic [9:0]  pixel_x;
   logic [9:0]  pixel_y;
   logic        frame_start;
   logic        locked;

   modport master (
      input  display_en,
      input  v_count_value,
      output enable_v_counter,
      output h_count,
      output hsync,
      output vsync,
      output video_on,
      output pixel_x,
      output pixel_y,
      output frame_start,
      output locked
   );

   modport slave (
      output display_en,
      output v_count_value,
      input  enable_v_counter,
      input  h_count,
      input  hsync,
      input  vsync,
      input  video_on,
      input  pixel_x,
      input  pixel_y,
      input  frame_start,
      input  locked
   );

endinterface

// File: rtl/vga_timing_controller_horizontal_counter.sv
// Free-running 0..TOTAL-1 pixel counter with a line-end strobe decoded
// straight from the count flop.
module horizontal_counter
   import vga_timing_pkg::*;
#(
   parameter int TOTAL = DEF_H_TOTAL
) (
   input  logic                 clk,
   input  logic                 srst,
   output logic [H_COUNT_W-1:0] count,
   output logic                 line_end
);

   localparam logic [H_COUNT_W-1:0] LAST = H_COUNT_W'(TOTAL - 1);

   logic [H_COUNT_W-1:0] count_reg;
   logic [H_COUNT_W-1:0] count_next;

   always_comb begin
      count_next = (count_reg == LAST) ? '0 : count_reg + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         count_reg <= '0;
      end else begin
         count_reg <= count_next;
      end
   end

   assign count    = count_reg;
   assign line_end = (count_reg == LAST);

endmodule

// File: rtl/vga_timing_controller.sv
// VGA raster sequencer: owns the h counter, strobes the external v counter
// and decodes registered sync/blank/coordinates. Macro: VGA_PIXEL_PREFETCH_EN.
module vga_timing_controller
   import vga_timing_pkg::*;
#(
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int H_FP     = DEF_H_FP,
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BP     = DEF_H_BP,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int V_FP     = DEF_V_FP,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BP     = DEF_V_BP
) (
   input  logic                    clk_25Mhz,
   input  logic                    rst,
   vga_timing_controller_if.master vga
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [H_COUNT_W-1:0] H_ACT_LIM  = H_COUNT_W'(H_ACTIVE);
   localparam logic [H_COUNT_W-1:0] HS_START   = H_COUNT_W'(H_ACTIVE + H_FP);
   localparam logic [H_COUNT_W-1:0] HS_END     = H_COUNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [V_COUNT_W-1:0] V_ACT_LIM  = V_COUNT_W'(V_ACTIVE);
   localparam logic [V_COUNT_W-1:0] VS_START   = V_COUNT_W'(V_ACTIVE + V_FP);
   localparam logic [V_COUNT_W-1:0] VS_END     = V_COUNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);
   localparam logic [V_COUNT_W-1:0] V_LAST     = V_COUNT_W'(V_TOTAL - 1);

   logic [H_COUNT_W-1:0] h_count;
   logic                 line_end;
   logic [V_COUNT_W-1:0] v_count;
   logic                 frame_end;

   state_t               state_reg;
   state_t               state_next;

   logic                 hsync_reg;
   logic                 vsync_reg;
   logic                 video_on_reg;
   logic [9:0]           pixel_x_reg;
   logic [9:0]           pixel_y_reg;
   logic                 frame_start_reg;
   logic                 locked_reg;

   logic                 run_now;
   logic                 active_now;
   logic                 hs_low_now;
   logic                 vs_low_now;
   logic                 frame_origin_now;

   horizontal_counter #(
      .TOTAL (H_TOTAL)
   ) u_horizontal_counter (
      .clk      (clk_25Mhz),
      .srst     (rst),
      .count    (h_count),
      .line_end (line_end)
   );

   assign v_count   = vga.v_count_value;
   assign frame_end = line_end && (v_count == V_LAST);

   // Mid-frame display_en changes are ignored in RUN; only the last line's wrap samples it.
   always_comb begin
      state_next = state_reg;
      unique case (state_reg)
         IDLE:    if (vga.display_en)                  state_next = ACQUIRE;
         ACQUIRE: if (frame_end)                       state_next = RUN;
         RUN:     if (frame_end && !vga.display_en)    state_next = DRAIN;
         DRAIN:   if (line_end)                        state_next = IDLE;
         default:                                      state_next = IDLE;
      endcase
   end

   // Out-of-range v values fall outside every active/sync window and so read as blanking.
   always_comb begin
      run_now          = (state_reg == RUN);
      active_now       = run_now && (h_count < H_ACT_LIM) && (v_count < V_ACT_LIM);
      hs_low_now       = run_now && (h_count >= HS_START) && (h_count <= HS_END);
      vs_low_now       = run_now && in_range16(v_count, VS_START, VS_END);
      frame_origin_now = run_now && (h_count == '0) && (v_count == '0);
   end

`ifdef VGA_PIXEL_PREFETCH_EN
   logic [H_COUNT_W-1:0] h_next;
   logic [V_COUNT_W-1:0] v_next;
   logic                 active_next;

   // Predict where the counters land after this edge so a registered BRAM
   // read launched now returns data aligned with video_on.
   always_comb begin
      h_next      = line_end ? '0 : h_count + 1'b1;
      v_next      = v_count;
      if (line_end && (state_reg != IDLE)) begin
         v_next = (v_count == V_LAST) ? '0 : v_count + 1'b1;
      end
      active_next = (state_next == RUN) && (h_next < H_ACT_LIM) && (v_next < V_ACT_LIM);
   end
`endif

   always_ff @(posedge clk_25Mhz) begin
      if (rst) begin
         state_reg       <= IDLE;
         hsync_reg       <= 1'b1;
         vsync_reg       <= 1'b1;
         video_on_reg    <= 1'b0;
         pixel_x_reg     <= '0;
         pixel_y_reg     <= '0;
         frame_start_reg <= 1'b0;
         locked_reg      <= 1'b0;
      end else begin
         state_reg       <= state_next;
         hsync_reg       <= !hs_low_now;
         vsync_reg       <= !vs_low_now;
         video_on_reg    <= active_now;
         frame_start_reg <= frame_origin_now;
         locked_reg      <= run_now;
`ifdef VGA_PIXEL_PREFETCH_EN
         pixel_x_reg     <= active_next ? h_next       : '0;
         pixel_y_reg     <= active_next ? v_next[9:0]  : '0;
`else
         pixel_x_reg     <= active_now  ? h_count      : '0;
         pixel_y_reg     <= active_now  ? v_count[9:0] : '0;
`endif
      end
   end

   assign vga.enable_v_counter = line_end && (state_reg != IDLE);
   assign vga.h_count          = h_count;
   assign vga.hsync            = hsync_reg;
   assign vga.vsync            = vsync_reg;
   assign vga.video_on         = video_on_reg;
   assign vga.pixel_x          = pixel_x_reg;
   assign vga.pixel_y          = pixel_y_reg;
   assign vga.frame_start      = frame_start_reg;
   assign vga.locked           = locked_reg;

endmodule
